sensor_emu: RTL

//   Bench/bring-up model of the 8-bit serial light-sensor ADC: the responder end of
//   the ncs/sck/sdo link driven by the sensor reader. Oversamples ncs and sck on clk,

---
 rtl/sensor_emu.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sensor_emu.sv
// rtl/sensor_emu.sv - responder model of the 8-bit serial light-sensor ADC
module sensor_emu #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 16,
    parameter int LEAD_ZEROS  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ncs,
    input  logic       sck,
    output logic       sdo,
    input  logic [7:0] sample,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort,
    output logic       overrun
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] FB_C   = CW'(FRAME_BITS);
    localparam logic [CW-1:0] SAT_C  = CW'(FRAME_BITS + 1);
    localparam logic [CW-1:0] LAST_C = CW'(FRAME_BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state, state_next;
    logic [SYNC_STAGES-1:0]  ncs_sync, sck_sync;
    logic                    ncs_prev, sck_prev;
    logic                    ncs_s, sck_s;
    logic                    ncs_fall, ncs_rise, sck_rise, sck_fall;
    logic                    do_load, do_end, do_rise, do_shift;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [CW-1:0]           rise_cnt, bit_cnt;

    // Synchronize the reader's pins; idle level of both lines is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ncs_sync <= '1;
            sck_sync <= '1;
            ncs_prev <= 1'b1;
            sck_prev <= 1'b1;
        end else begin
            ncs_sync <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
            ncs_prev <= ncs_sync[SYNC_STAGES-1];
            sck_prev <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign ncs_s    = ncs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ncs_fall = ncs_prev & ~ncs_s;
    assign ncs_rise = ~ncs_prev & ncs_s;
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;

    // Leading zeros, data MSB first, zero padding to the frame length
    assign frame_word = {sample, {(FRAME_BITS-8){1'b0}}} >> LEAD_ZEROS;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next state and datapath strobes; ncs edges take precedence over sck edges
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_end     = 1'b0;
        do_rise    = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (ncs_fall) begin
                    do_load    = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    do_end     = 1'b1;
                    state_next = IDLE;
                end else begin
                    do_rise  = sck_rise;
                    do_shift = sck_fall && (rise_cnt != '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, edge counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            rise_cnt    <= '0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (do_load) begin
                shreg    <= frame_word;
                rise_cnt <= '0;
                bit_cnt  <= '0;
                overrun  <= 1'b0;
            end
            if (do_end) begin
                shreg       <= '0;
                frame_done  <= (rise_cnt >= FB_C);
                frame_abort <= (rise_cnt < FB_C);
            end
            if (do_rise) begin
                if (rise_cnt != SAT_C) rise_cnt <= rise_cnt + 1'b1;
                if (rise_cnt >= FB_C)  overrun  <= 1'b1;
            end
            if (do_shift) begin
                // Past the last frame bit the line is held low
                if (bit_cnt >= LAST_C) shreg <= '0;
                else                   shreg <= shreg << 1;
                if (bit_cnt != FB_C)   bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign sdo  = (state == SHIFT) & shreg[FRAME_BITS-1];

endmodule
